// File: rtl/register_transfer_sequencer_pkg.sv
// Shared encodings for the register transfer sequencer:
// unit indices, instruction classes, SYS codes and FSM states.
package register_transfer_sequencer_pkg;

  localparam int UNIT_W = 6;

  localparam logic [2:0] U_MEM = 3'd0;
  localparam logic [2:0] U_AR  = 3'd1;
  localparam logic [2:0] U_DR0 = 3'd2;
  localparam logic [2:0] U_DR1 = 3'd3;
  localparam logic [2:0] U_ALU = 3'd4;
  localparam logic [2:0] U_PC  = 3'd5;

  typedef enum logic [1:0] {
    C_MOVE = 2'b00,
    C_LDI  = 2'b01,
    C_ALU  = 2'b10,
    C_SYS  = 2'b11
  } cls_e;

  localparam logic [7:0] SYS_HALT = 8'hC0;
  localparam logic [7:0] SYS_NOP  = 8'hC1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_e;

  // Indices 6-7 map to no unit at all.
  function automatic logic [UNIT_W-1:0] onehot(
    input logic [2:0] idx
  );
    logic [7:0] w_full;
    w_full = 8'd1 << idx;
    return w_full[UNIT_W-1:0];
  endfunction

endpackage

// File: rtl/register_transfer_sequencer_instr_decoder.sv
// Combinational instruction decode: splits IR into
// class/src/dst and flags illegal, HALT and NOP encodings.
module register_transfer_sequencer_instr_decoder
  import register_transfer_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_ir,
  output cls_e                  o_cls,
  output logic [2:0]            o_src,
  output logic [2:0]            o_dst,
  output logic                  o_illegal,
  output logic                  o_halt,
  output logic                  o_nop
);

  logic [7:0] w_ir;
  logic       w_bad_src;
  logic       w_bad_dst;

  assign w_ir      = i_ir[7:0];
  assign o_cls     = cls_e'(w_ir[7:6]);
  assign o_src     = w_ir[5:3];
  assign o_dst     = w_ir[2:0];
  assign w_bad_src = (o_src > U_PC);
  assign w_bad_dst = (o_dst > U_PC);
  assign o_halt    = (w_ir == SYS_HALT);
  assign o_nop     = (w_ir == SYS_NOP);

  always_comb begin
    o_illegal = 1'b0;
    unique case (1'b1)
      (o_cls == C_MOVE): o_illegal = w_bad_src | w_bad_dst;
      (o_cls == C_LDI):  o_illegal = w_bad_dst;
      (o_cls == C_ALU):  o_illegal = w_bad_src | w_bad_dst;
      default:           o_illegal = !(o_halt | o_nop);
    endcase
  end

endmodule

// File: rtl/register_transfer_sequencer.sv
// Fetch/decode/execute FSM driving the unit bus enables,
// memory read handshake and PC increment.
module register_transfer_sequencer
  import register_transfer_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_run,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic                  i_mem_ack,
  output logic                  o_mem_req,
  output logic                  o_action_read_addr_source,
  output logic                  o_pc_counter_en,
  output logic [UNIT_W-1:0]     o_unit_reg_input_en,
  output logic [UNIT_W-1:0]     o_unit_reg_output_en,
  output logic [UNIT_W-1:0]     o_unit_alu_output_en,
  output logic                  o_busy,
  output logic                  o_halted,
  output logic                  o_illegal
);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_ir;
  logic                  r_run_q;
  logic                  r_mem_req;
  logic                  r_addr_src;
  logic                  r_pc_en;
  logic [UNIT_W-1:0]     r_in_en;
  logic [UNIT_W-1:0]     r_out_en;
  logic [UNIT_W-1:0]     r_alu_en;
  logic                  r_busy;
  logic                  r_halted;
  logic                  r_illegal;

  cls_e       w_cls;
  logic [2:0] w_src;
  logic [2:0] w_dst;
  logic       w_illegal;
  logic       w_halt;
  logic       w_nop;

  register_transfer_sequencer_instr_decoder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_instr_decoder (
    .i_ir      (r_ir),
    .o_cls     (w_cls),
    .o_src     (w_src),
    .o_dst     (w_dst),
    .o_illegal (w_illegal),
    .o_halt    (w_halt),
    .o_nop     (w_nop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_run_q    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_addr_src <= 1'b1;
      r_pc_en    <= 1'b0;
      r_in_en    <= '0;
      r_out_en   <= '0;
      r_alu_en   <= '0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_run_q  <= i_run;
      r_pc_en  <= 1'b0;
      r_in_en  <= '0;
      r_out_en <= '0;
      r_alu_en <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_addr_src <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_mem_ack) begin
            r_ir      <= i_instr;
            r_pc_en   <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_halted  <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_HALT;
          end else begin
            unique case (1'b1)
              w_halt: begin
                r_halted <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= S_HALT;
              end
              w_nop: begin
                r_state    <= i_run ? S_FETCH : S_IDLE;
                r_mem_req  <= i_run;
                r_busy     <= i_run;
                r_addr_src <= 1'b1;
              end
              (w_cls == C_MOVE && w_src == U_MEM): begin
                r_state    <= S_MEMRD;
                r_mem_req  <= 1'b1;
                r_addr_src <= 1'b0;
              end
              (w_cls == C_LDI): begin
                r_state    <= S_IMM;
                r_mem_req  <= 1'b1;
                r_addr_src <= 1'b1;
              end
              default: r_state <= S_EXEC;
            endcase
          end
        end
        S_MEMRD: begin
          if (i_mem_ack) begin
            r_out_en   <= onehot(U_MEM);
            r_in_en    <= onehot(w_dst);
            r_state    <= i_run ? S_FETCH : S_IDLE;
            r_mem_req  <= i_run;
            r_busy     <= i_run;
            r_addr_src <= 1'b1;
          end
        end
        S_IMM: begin
          if (i_mem_ack) begin
            r_out_en   <= onehot(U_MEM);
            r_in_en    <= onehot(w_dst);
            r_pc_en    <= 1'b1;
            r_state    <= i_run ? S_FETCH : S_IDLE;
            r_mem_req  <= i_run;
            r_busy     <= i_run;
            r_addr_src <= 1'b1;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            (w_cls == C_ALU): begin
              r_alu_en <= onehot(w_src);
              r_in_en  <= onehot(w_dst);
            end
            default: begin
              r_out_en <= onehot(w_src);
              r_in_en  <= onehot(w_dst);
            end
          endcase
          r_state    <= i_run ? S_FETCH : S_IDLE;
          r_mem_req  <= i_run;
          r_busy     <= i_run;
          r_addr_src <= 1'b1;
        end
        S_HALT: begin
          // Restart needs a fresh 0->1 on i_run, not a level.
          if (i_run && !r_run_q) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_addr_src <= 1'b1;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_mem_req  <= 1'b0;
          r_addr_src <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req                 = r_mem_req;
  assign o_action_read_addr_source = r_addr_src;
  assign o_pc_counter_en           = r_pc_en;
  assign o_unit_reg_input_en       = r_in_en;
  assign o_unit_reg_output_en      = r_out_en;
  assign o_unit_alu_output_en      = r_alu_en;
  assign o_busy                    = r_busy;
  assign o_halted                  = r_halted;
  assign o_illegal                 = r_illegal;

endmodule
